// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI read arbiter.
package axi_rd_pkg;

    localparam int unsigned AXI_ADDR_W = 40;
    localparam int unsigned AXI_DATA_W = 128;
    localparam int unsigned AXI_ID_W   = 4;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } ar_req_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } r_beat_t;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
    } arb_state_e;

endpackage

// File: rtl/axi_rd_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_i, wrapping.
module rr_picker #(
    parameter int unsigned NUM_MST = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_MST-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_MST-1:0] gnt_oh_o,
    output logic [IDX_W-1:0]   gnt_idx_o
);

    int unsigned cand;

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        cand      = 0;
        for (int unsigned k = NUM_MST; k >= 1; k--) begin
            cand = (32'(last_i) + k) % NUM_MST;
            if (req_i[cand]) begin
                gnt_oh_o       = '0;
                gnt_oh_o[cand] = 1'b1;
                gnt_idx_o      = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// N-master to one-slave AXI read arbiter, one burst in flight, with length and stall monitors.
module axi_rd_arbiter
    import axi_rd_pkg::*;
#(
    parameter int unsigned NUM_MST     = 2,
    parameter int unsigned ADDR_WIDTH  = 40,
    parameter int unsigned DATA_WIDTH  = 128,
    parameter int unsigned ID_WIDTH    = 4,
    parameter int unsigned STALL_LIMIT = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  ar_req_t [NUM_MST-1:0] m_ar,
    input  logic    [NUM_MST-1:0] m_ar_valid,
    output logic    [NUM_MST-1:0] m_ar_ready,
    output r_beat_t [NUM_MST-1:0] m_r,
    output logic    [NUM_MST-1:0] m_r_valid,
    input  logic    [NUM_MST-1:0] m_r_ready,
    output ar_req_t               s_ar,
    output logic                  s_ar_valid,
    input  logic                  s_ar_ready,
    input  r_beat_t               s_r,
    input  logic                  s_r_valid,
    output logic                  s_r_ready,
    output logic                  err_len,
    output logic                  err_stall,
    input  logic                  err_clr
);

    localparam int unsigned IdxW   = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);
    localparam logic [StallW-1:0] StallMax = StallW'(STALL_LIMIT);

    // Struct widths are fixed by the package; the parameters must agree with it.
    if (ADDR_WIDTH != AXI_ADDR_W || DATA_WIDTH != AXI_DATA_W || ID_WIDTH != AXI_ID_W)
    begin : g_width_chk
        $error("axi_rd_arbiter: width parameters disagree with axi_rd_pkg");
    end
    if (NUM_MST < 2 || NUM_MST > 8) begin : g_mst_chk
        $error("axi_rd_arbiter: NUM_MST must be 2..8");
    end

    arb_state_e          state_q, state_d;
    logic [IdxW-1:0]     grant_q, grant_d;
    logic [IdxW-1:0]     last_q, last_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          beat_q, beat_d;
    logic [StallW-1:0]   stall_q, stall_d;
    logic                err_len_q, err_len_d;
    logic                err_stall_q, err_stall_d;
    logic [NUM_MST-1:0]  pick_oh;
    logic [IdxW-1:0]     pick_idx;
    logic                ar_hs, r_hs, len_bad, stall_hit;

    rr_picker #(
        .NUM_MST (NUM_MST),
        .IDX_W   (IdxW)
    ) u_rr_picker (
        .req_i     (m_ar_valid),
        .last_i    (last_q),
        .gnt_oh_o  (pick_oh),
        .gnt_idx_o (pick_idx)
    );

    assign ar_hs     = s_ar_valid & s_ar_ready;
    assign r_hs      = s_r_valid & s_r_ready;
    assign err_len   = err_len_q;
    assign err_stall = err_stall_q;

    // Channel routing: only the granted master is connected, and only in its phase.
    always_comb begin
        s_ar       = '0;
        s_ar_valid = 1'b0;
        s_r_ready  = 1'b0;
        m_ar_ready = '0;
        m_r        = '0;
        m_r_valid  = '0;
        unique case (state_q)
            StAddr: begin
                s_ar                = m_ar[grant_q];
                s_ar_valid          = 1'b1;
                m_ar_ready[grant_q] = s_ar_ready;
            end
            StData: begin
                m_r[grant_q]       = s_r;
                m_r_valid[grant_q] = s_r_valid;
                s_r_ready          = m_r_ready[grant_q];
            end
            default: ;
        endcase
    end

    // Next-state: arbitration, beat/stall counting and sticky error flags.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        len_d     = len_q;
        beat_d    = beat_q;
        stall_d   = stall_q;
        len_bad   = 1'b0;
        stall_hit = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|pick_oh) begin
                    grant_d = pick_idx;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (ar_hs) begin
                    len_d   = s_ar.len;
                    beat_d  = '0;
                    stall_d = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (r_hs) begin
                    beat_d  = beat_q + 8'd1;
                    stall_d = '0;
                    // The slave's RLAST is authoritative for the FSM; mismatch is only flagged.
                    len_bad = s_r.last != (beat_q == len_q);
                    if (s_r.last) begin
                        last_d  = grant_q;
                        state_d = StIdle;
                    end
                end else if (stall_q != StallMax) begin
                    stall_d   = stall_q + StallW'(1);
                    stall_hit = (stall_q == StallMax - StallW'(1));
                end
            end
            default: state_d = StIdle;
        endcase
        // A set event in the same cycle as err_clr wins.
        err_len_d   = len_bad   ? 1'b1 : (err_clr ? 1'b0 : err_len_q);
        err_stall_d = stall_hit ? 1'b1 : (err_clr ? 1'b0 : err_stall_q);
    end

    // State registers; reset abandons any burst and restarts arbitration at master 0.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            last_q      <= IdxW'(NUM_MST - 1);
            len_q       <= '0;
            beat_q      <= '0;
            stall_q     <= '0;
            err_len_q   <= 1'b0;
            err_stall_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            stall_q     <= stall_d;
            err_len_q   <= err_len_d;
            err_stall_q <= err_stall_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: transaction-level model plus directed scenarios.
module tb_axi_rd_arbiter;
    import axi_rd_pkg::*;

    localparam int NMST = 2;
    localparam int SLIM = 16;

    logic                ACLK    = 1'b0;
    logic                ARESETn = 1'b0;
    ar_req_t [NMST-1:0]  m_ar;
    logic    [NMST-1:0]  m_ar_valid, m_ar_ready;
    r_beat_t [NMST-1:0]  m_r;
    logic    [NMST-1:0]  m_r_valid, m_r_ready;
    ar_req_t             s_ar;
    logic                s_ar_valid, s_ar_ready;
    r_beat_t             s_r;
    logic                s_r_valid, s_r_ready;
    logic                err_len, err_stall, err_clr;

    axi_rd_arbiter #(
        .NUM_MST     (NMST),
        .STALL_LIMIT (SLIM)
    ) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .m_ar       (m_ar),
        .m_ar_valid (m_ar_valid),
        .m_ar_ready (m_ar_ready),
        .m_r        (m_r),
        .m_r_valid  (m_r_valid),
        .m_r_ready  (m_r_ready),
        .s_ar       (s_ar),
        .s_ar_valid (s_ar_valid),
        .s_ar_ready (s_ar_ready),
        .s_r        (s_r),
        .s_r_valid  (s_r_valid),
        .s_r_ready  (s_r_ready),
        .err_len    (err_len),
        .err_stall  (err_stall),
        .err_clr    (err_clr)
    );

    always #5 ACLK = ~ACLK;

    int n_chk = 0;
    int n_err = 0;

    // Slave responder and stimulus knobs.
    bit          sl_act     = 1'b0;
    int          sl_beat    = 0;
    int          sl_last    = 0;
    logic [39:0] sl_addr    = '0;
    logic [3:0]  sl_id      = '0;
    bit          sl_hold    = 1'b0;
    int          force_last = -1;
    bit          tog1       = 1'b0;

    // Handshakes observed at the negedge, i.e. those that complete on the next posedge.
    bit             s_arf_s = 1'b0;
    bit             rf_s    = 1'b0;
    logic [NMST-1:0] arf_s  = '0;
    logic [7:0]     s_ar_len_s  = '0;
    logic [39:0]    s_ar_addr_s = '0;
    logic [3:0]     s_ar_id_s   = '0;

    logic [127:0] rq0[$];
    logic [127:0] rq1[$];
    int           gq[$];

    // Transaction-level model state.
    int mo_owner  = -1;
    bit mo_addr   = 1'b0;
    int mo_ptr    = 0;
    int mo_beats  = 0;
    int mo_len    = 0;
    int mo_quiet  = 0;
    bit mo_elen   = 1'b0;
    bit mo_estall = 1'b0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic issue(input int m, input logic [39:0] addr, input logic [7:0] len);
        m_ar[m].id    = 4'(m + 1);
        m_ar[m].addr  = addr;
        m_ar[m].len   = len;
        m_ar[m].size  = 3'd4;
        m_ar[m].burst = BURST_INCR;
        m_ar_valid[m] = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            cyc(1);
            if (m_ar_valid == '0 && !sl_act && mo_owner < 0) break;
        end
        if (n >= budget) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_idle: got busy want idle within %0d cycles", budget);
        end
    endtask

    task automatic chk_q(input string nm, input int mst, input logic [127:0] base, input int n);
        int sz;
        logic [127:0] got;
        sz = (mst == 0) ? rq0.size() : rq1.size();
        chk({nm, "_cnt"}, sz, n);
        for (int k = 0; k < sz && k < n; k++) begin
            got = (mst == 0) ? rq0[k] : rq1[k];
            chk({nm, "_beat"}, got, base + 128'(k));
        end
    endtask

    // Model: one burst in flight, round-robin from the master after the last served one.
    initial begin : model
        forever begin
            @(posedge ACLK or negedge ARESETn);
            if (!ARESETn) begin
                mo_owner  = -1;
                mo_addr   = 1'b0;
                mo_ptr    = 0;
                mo_beats  = 0;
                mo_len    = 0;
                mo_quiet  = 0;
                mo_elen   = 1'b0;
                mo_estall = 1'b0;
            end else begin
                bit set_l, set_s;
                set_l = 1'b0;
                set_s = 1'b0;
                if (mo_owner < 0) begin
                    for (int k = 0; k < NMST; k++) begin
                        int c;
                        c = (mo_ptr + k) % NMST;
                        if (mo_owner < 0 && m_ar_valid[c]) begin
                            mo_owner = c;
                            mo_addr  = 1'b1;
                        end
                    end
                end else if (mo_addr) begin
                    if (s_ar_ready) begin
                        mo_len   = int'(m_ar[mo_owner].len);
                        mo_beats = 0;
                        mo_quiet = 0;
                        mo_addr  = 1'b0;
                    end
                end else if (s_r_valid && m_r_ready[mo_owner]) begin
                    if (s_r.last != (mo_beats == mo_len)) set_l = 1'b1;
                    mo_beats = (mo_beats + 1) % 256;
                    mo_quiet = 0;
                    if (s_r.last) begin
                        mo_ptr   = (mo_owner + 1) % NMST;
                        mo_owner = -1;
                    end
                end else if (mo_quiet < SLIM) begin
                    mo_quiet++;
                    if (mo_quiet == SLIM) set_s = 1'b1;
                end
                mo_elen   = set_l ? 1'b1 : (err_clr ? 1'b0 : mo_elen);
                mo_estall = set_s ? 1'b1 : (err_clr ? 1'b0 : mo_estall);
            end
        end
    end

    ar_req_t             e_sar;
    r_beat_t [NMST-1:0]  e_mr;
    logic    [NMST-1:0]  e_arr, e_rv;
    logic                e_sarv, e_srr;

    // Per-cycle compare against the model, plus handshake sampling for the stimulus side.
    initial begin : compare
        forever begin
            @(negedge ACLK);
            e_sar  = '0;
            e_mr   = '0;
            e_arr  = '0;
            e_rv   = '0;
            e_sarv = 1'b0;
            e_srr  = 1'b0;
            if (ARESETn && mo_owner >= 0) begin
                if (mo_addr) begin
                    e_sarv          = 1'b1;
                    e_sar           = m_ar[mo_owner];
                    e_arr[mo_owner] = s_ar_ready;
                end else begin
                    e_mr[mo_owner] = s_r;
                    e_rv[mo_owner] = s_r_valid;
                    e_srr          = m_r_ready[mo_owner];
                end
            end
            chk("s_ar_valid", s_ar_valid, e_sarv);
            chk("s_ar", s_ar, e_sar);
            chk("m_ar_ready", m_ar_ready, e_arr);
            chk("m_r_valid", m_r_valid, e_rv);
            chk("m_r", m_r, e_mr);
            chk("s_r_ready", s_r_ready, e_srr);
            chk("err_len", err_len, mo_elen);
            chk("err_stall", err_stall, mo_estall);

            s_arf_s     = s_ar_valid && s_ar_ready;
            rf_s        = s_r_valid && s_r_ready;
            s_ar_len_s  = s_ar.len;
            s_ar_addr_s = s_ar.addr;
            s_ar_id_s   = s_ar.id;
            for (int i = 0; i < NMST; i++) begin
                arf_s[i] = m_ar_valid[i] && m_ar_ready[i];
                if (arf_s[i]) gq.push_back(i);
            end
            if (m_r_valid[0] && m_r_ready[0]) rq0.push_back(m_r[0].data);
            if (m_r_valid[1] && m_r_ready[1]) rq1.push_back(m_r[1].data);
        end
    end

    // Environment: masters drop valid after handshake; slave returns addr+beat data.
    initial begin : env
        forever begin
            @(posedge ACLK);
            #1;
            for (int i = 0; i < NMST; i++) begin
                if (arf_s[i]) m_ar_valid[i] = 1'b0;
            end
            if (!ARESETn) begin
                sl_act = 1'b0;
            end else if (s_arf_s) begin
                sl_act  = 1'b1;
                sl_beat = 0;
                sl_addr = s_ar_addr_s;
                sl_id   = s_ar_id_s;
                sl_last = (force_last >= 0) ? force_last : int'(s_ar_len_s);
            end else if (rf_s && sl_act) begin
                if (sl_beat == sl_last) sl_act = 1'b0;
                else sl_beat++;
            end
            s_r_valid  = sl_act && !sl_hold;
            s_r.id     = sl_id;
            s_r.data   = 128'(sl_addr) + 128'(sl_beat);
            s_r.resp   = RESP_OKAY;
            s_r.last   = (sl_beat == sl_last);
            if (tog1) m_r_ready[1] = ~m_r_ready[1];
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: got no finish want finish by 50000");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int n;
        m_ar       = '0;
        m_ar_valid = '0;
        m_r_ready  = '1;
        s_ar_ready = 1'b1;
        s_r        = '0;
        s_r_valid  = 1'b0;
        err_clr    = 1'b0;

        // Reset state.
        cyc(2);
        @(negedge ACLK);
        chk("rst_state", {s_ar_valid, s_r_ready, m_ar_ready, m_r_valid, err_len, err_stall}, '0);
        chk("rst_data", {m_r, s_ar}, '0);
        cyc(1);
        ARESETn = 1'b1;
        cyc(1);

        // Single read, m0 len 3.
        issue(0, 40'h100, 8'd3);
        @(negedge ACLK);
        chk("ar_lat_idle", s_ar_valid, 1'b0);
        @(posedge ACLK);
        #1;
        @(negedge ACLK);
        chk("ar_lat_next", s_ar_valid, 1'b1);
        chk("ar_addr", s_ar.addr, 40'h100);
        chk("ar_ready_m0", m_ar_ready, 2'b01);
        wait_idle(100);
        chk_q("single_m0", 0, 128'h100, 4);
        chk_q("single_m1", 1, 128'h0, 0);

        // Contention after reset: m0 first, then alternation.
        ARESETn = 1'b0;
        cyc(2);
        ARESETn = 1'b1;
        cyc(1);
        gq.delete();
        rq0.delete();
        rq1.delete();
        issue(0, 40'h1000, 8'd1);
        issue(1, 40'h2000, 8'd1);
        wait_idle(100);
        issue(0, 40'h3000, 8'd1);
        issue(1, 40'h4000, 8'd1);
        wait_idle(100);
        chk("rr_cnt", gq.size(), 4);
        for (int k = 0; k < gq.size() && k < 4; k++) chk("rr_order", gq[k], k % 2);
        chk("rr_m0_beats", rq0.size(), 4);
        chk("rr_m1_beats", rq1.size(), 4);

        // Backpressure: m1 len 7 with m1 ready toggling every cycle.
        rq0.delete();
        rq1.delete();
        issue(1, 40'h200, 8'd7);
        tog1 = 1'b1;
        wait_idle(200);
        tog1 = 1'b0;
        m_r_ready[1] = 1'b1;
        chk_q("bp_m1", 1, 128'h200, 8);
        chk_q("bp_m0", 0, 128'h0, 0);

        // Length error: len 3 but slave ends after the second beat.
        rq0.delete();
        force_last = 1;
        issue(0, 40'h600, 8'd3);
        wait_idle(100);
        force_last = -1;
        @(negedge ACLK);
        chk("len_err_set", err_len, 1'b1);
        chk("len_idle", {s_ar_valid, s_r_ready}, 2'b00);
        chk_q("len_m0", 0, 128'h600, 2);
        @(posedge ACLK);
        #1;
        err_clr = 1'b1;
        @(negedge ACLK);
        chk("len_err_hold", err_len, 1'b1);
        @(posedge ACLK);
        #1;
        err_clr = 1'b0;
        @(negedge ACLK);
        chk("len_err_clr", err_len, 1'b0);
        cyc(1);

        // Stall: slave withholds R for more than STALL_LIMIT cycles.
        rq1.delete();
        sl_hold = 1'b1;
        issue(1, 40'h700, 8'd1);
        for (n = 0; n < 50; n++) begin
            @(negedge ACLK);
            if (s_r_ready) break;
        end
        chk("stall_enter", s_r_ready, 1'b1);
        repeat (15) @(posedge ACLK);
        @(negedge ACLK);
        chk("stall_pre", err_stall, 1'b0);
        @(posedge ACLK);
        @(negedge ACLK);
        chk("stall_set", err_stall, 1'b1);
        @(posedge ACLK);
        #1;
        sl_hold = 1'b0;
        wait_idle(50);
        chk_q("stall_m1", 1, 128'h700, 2);
        chk("stall_sticky", err_stall, 1'b1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        cyc(1);
        chk("stall_clr", err_stall, 1'b0);

        // Reset mid-burst: m0 served last, then m1 cut off during its second beat.
        rq0.delete();
        issue(0, 40'h800, 8'd0);
        wait_idle(50);
        rq1.delete();
        issue(1, 40'h900, 8'd3);
        for (n = 0; n < 50; n++) begin
            cyc(1);
            if (rq1.size() >= 1) break;
        end
        chk("mid_beat1", rq1.size(), 1);
        ARESETn = 1'b0;
        @(negedge ACLK);
        chk("mid_rst_out", {s_ar_valid, s_r_ready, m_ar_ready, m_r_valid}, '0);
        chk("mid_rst_data", {m_r, s_ar}, '0);
        m_ar_valid = '0;
        cyc(2);
        ARESETn = 1'b1;
        cyc(1);
        gq.delete();
        issue(0, 40'ha00, 8'd0);
        issue(1, 40'hb00, 8'd0);
        wait_idle(100);
        chk("post_rst_cnt", gq.size(), 2);
        if (gq.size() >= 2) begin
            chk("post_rst_first", gq[0], 0);
            chk("post_rst_second", gq[1], 1);
        end

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
